// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit_if
//  Description : Operand/result bundle between the control FSM and the
//                sequential divider. master = requester, slave = divider.
//  Revision    : 1.0 - initial release
// ============================================================================
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div0, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Sequential signed divider (MIPS DIV semantics). Radix-2
//                restoring on operand magnitudes, one quotient bit per clock,
//                followed by a sign-fix cycle. lo = quotient, hi = remainder.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_div0;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_dvsr;
  logic [CW-1:0]    r_count;
  logic             r_sign_q;
  logic             r_sign_r;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;

  // Operand magnitudes; the most negative value maps onto itself, which is
  // exactly its magnitude when read as unsigned.
  always_comb begin
    w_a_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    w_b_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The extra top bit makes the borrow of the trial subtraction the compare.
  always_comb begin
    w_trial    = {r_rem, r_q[WIDTH-1]};
    w_diff     = w_trial - {1'b0, r_dvsr};
    w_ge       = ~w_diff[WIDTH];
    w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    w_q_next   = {r_q[WIDTH-2:0], w_ge};
  end

  // Control FSM and datapath registers; all outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_div0   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_dvsr   <= '0;
      r_count  <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          r_div0 <= 1'b0;
          if (bus.start) begin
            if (bus.divisor == '0) begin
              // Divide by zero: flag it immediately, results untouched.
              r_done <= 1'b1;
              r_div0 <= 1'b1;
            end else begin
              r_sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
              r_sign_r <= bus.dividend[WIDTH-1];
              r_q      <= w_a_mag;
              r_dvsr   <= w_b_mag;
              r_rem    <= '0;
              r_count  <= LAST_COUNT;
              r_busy   <= 1'b1;
              r_state  <= RUN;
            end
          end
        end
        RUN: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          if (r_count == '0) begin
            r_state <= FIX;
          end else begin
            r_count <= r_count - CW'(1);
          end
        end
        FIX: begin
          r_lo    <= r_sign_q ? -r_q   : r_q;
          r_hi    <= r_sign_r ? -r_rem : r_rem;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.div0 = r_div0;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Scoreboard bench for div_unit. Stimulus pushes the expected
//                result (from plain signed arithmetic) and completion cycle;
//                a monitor pops and compares on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

  localparam int WIDTH = 32;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        div0;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];
  logic [31:0] last_lo;
  logic [31:0] last_hi;

  div_unit_if #(.WIDTH(WIDTH)) bus ();

  div_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: MIPS DIV is C-style truncating division on signed values.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint da;
    longint db;
    longint q;
    longint r;
    if (b == 32'd0) begin
      e.lo   = last_lo;
      e.hi   = last_hi;
      e.div0 = 1'b1;
      e.cyc  = cyc + 1;
    end else begin
      da     = longint'($signed(a));
      db     = longint'($signed(b));
      q      = da / db;
      r      = da % db;
      e.lo   = q[31:0];
      e.hi   = r[31:0];
      e.div0 = 1'b0;
      e.cyc  = cyc + 34;
    end
    return e;
  endfunction

  // Caller is at a negedge; start is sampled by the following posedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    e = model(a, b);
    sb.push_back(e);
    last_lo = e.lo;
    last_hi = e.hi;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("lo", bus.lo, e.lo);
        chk("hi", bus.hi, e.hi);
        chk("div0", {31'd0, bus.div0}, {31'd0, e.div0});
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    last_lo      = '0;
    last_hi      = '0;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    #2;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_div0", {31'd0, bus.div0}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Basic positive division, with busy observed mid-operation
    issue(32'd100, 32'd7);
    chk("busy_run", {31'd0, bus.busy}, 32'd1);
    wait_idle();
    chk("busy_after", {31'd0, bus.busy}, 32'd0);

    // Divide by zero keeps previous hi/lo
    issue(32'd5, 32'd0);
    chk("busy_div0", {31'd0, bus.busy}, 32'd0);
    wait_idle();

    // Sign combinations and overflow boundary
    issue(-32'sd7, 32'd2);          wait_idle();
    issue(32'd7, -32'sd2);          wait_idle();
    issue(-32'sd7, -32'sd2);        wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    issue(32'h8000_0000, 32'd1);    wait_idle();

    // Start while busy is ignored; start during done cycle is accepted
    @(negedge clk);
    issue(32'd100, 32'd7);
    repeat (3) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd9;
    bus.divisor  = 32'd3;
    @(negedge clk);
    bus.start    = 1'b0;
    begin
      int n = 0;
      while (!bus.done && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!bus.done) begin
        checks++;
        errors++;
        $display("FAIL done_wait: got done=0 expected done=1");
      end
    end
    issue(32'd9, 32'd3);
    wait_idle();

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = 32'($signed($urandom_range(0, 2000)) - 1000);
                 b = 32'($signed($urandom_range(0, 60)) - 30); end
        2: begin a = $urandom; b = 32'd0; end
        3: begin a = 32'h8000_0000;
                 b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom; end
        default: begin a = $urandom; b = 32'($urandom_range(1, 255)); end
      endcase
      issue(a, b);
      wait_idle();
    end

    // Asynchronous reset in the middle of RUN
    issue(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_done", {31'd0, bus.done}, 32'd0);
    chk("arst_hi", bus.hi, 32'd0);
    chk("arst_lo", bus.lo, 32'd0);
    sb.delete();
    last_lo = '0;
    last_hi = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    issue(32'd100, 32'd7);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
